// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: hazard inputs from the datapath, enable/clear controls back to it.
// master = datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
   parameter int REG_BITS = 6
);
   logic [REG_BITS-1:0] id_rs;
   logic                id_rs_used;
   logic [REG_BITS-1:0] id_rt;
   logic                id_rt_used;
   logic                ex_ld;
   logic [REG_BITS-1:0] ex_write;
   logic                ex_muldiv;
   logic                ex_branch_taken;
   logic                halt_req;
   logic                resume;
   logic                pc_en;
   logic                if_id_en;
   logic                id_ex_en;
   logic                ex_mem_en;
   logic                mem_wb_en;
   logic                if_id_zero;
   logic                id_ex_zero;
   logic                ex_mem_zero;
   logic                mem_wb_zero;
   logic                halted;

   modport master (
      output id_rs, id_rs_used, id_rt, id_rt_used, ex_ld, ex_write,
             ex_muldiv, ex_branch_taken, halt_req, resume,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_zero, id_ex_zero, ex_mem_zero, mem_wb_zero, halted
   );

   modport slave (
      input  id_rs, id_rs_used, id_rt, id_rt_used, ex_ld, ex_write,
             ex_muldiv, ex_branch_taken, halt_req, resume,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_zero, id_ex_zero, ex_mem_zero, mem_wb_zero, halted
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, branch squash, mul/div occupancy, halt/resume.
// Optional HAZARD_CTRL_PERF_EN adds load-use / mul-div / branch event counters.
module hazard_ctrl #(
   parameter int MULDIV_CYCLES = 4,
   parameter int CNT_BITS      = 4,
   parameter int REG_BITS      = 6
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  hz
`ifdef HAZARD_CTRL_PERF_EN
   ,
   output logic [31:0]   perf_lu_cnt,
   output logic [31:0]   perf_md_cnt,
   output logic [31:0]   perf_br_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_MULDIV = 2'd1,
      ST_HALT   = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [CNT_BITS-1:0] cnt_r;
   logic [CNT_BITS-1:0] cnt_nxt_s;
   logic                saved_md_r;
   logic                saved_md_nxt_s;
   logic                load_use_s;

   // Decision logic: outputs react in the same cycle the hazard is visible.
   always_comb begin
      load_use_s = hz.ex_ld && (hz.ex_write != {REG_BITS{1'b0}}) &&
                   ((hz.id_rs_used && (hz.id_rs == hz.ex_write)) ||
                    (hz.id_rt_used && (hz.id_rt == hz.ex_write)));
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      saved_md_nxt_s = saved_md_r;
      hz.pc_en       = 1'b1;
      hz.if_id_en    = 1'b1;
      hz.id_ex_en    = 1'b1;
      hz.ex_mem_en   = 1'b1;
      hz.mem_wb_en   = 1'b1;
      hz.if_id_zero  = 1'b0;
      hz.id_ex_zero  = 1'b0;
      hz.ex_mem_zero = 1'b0;
      hz.mem_wb_zero = 1'b0;
      hz.halted      = 1'b0;
      if (rst) begin
         {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en} = 5'b00000;
         {hz.if_id_zero, hz.id_ex_zero, hz.ex_mem_zero, hz.mem_wb_zero} = 4'b1111;
      end else begin
         case (state_r)
            ST_HALT: begin
               {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en} = 5'b00000;
               hz.halted = 1'b1;
               if (hz.resume) begin
                  state_nxt_s = saved_md_r ? ST_MULDIV : ST_RUN;
               end else begin
                  state_nxt_s = ST_HALT;
               end
            end
            ST_RUN, ST_MULDIV: begin
               if (hz.halt_req) begin
                  {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en} = 5'b00000;
                  saved_md_nxt_s = (state_r == ST_MULDIV);
                  state_nxt_s    = ST_HALT;
               end else if ((state_r == ST_MULDIV) && (cnt_r == {CNT_BITS{1'b0}})) begin
                  // Release cycle: the mul/div result moves on, ex_muldiv is not re-sampled.
                  state_nxt_s = ST_RUN;
               end else if ((state_r == ST_MULDIV) || hz.ex_muldiv) begin
                  {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en} = 4'b0000;
                  hz.mem_wb_zero = 1'b1;
                  state_nxt_s    = ST_MULDIV;
                  if (state_r == ST_MULDIV) begin
                     cnt_nxt_s = cnt_r - CNT_BITS'(1);
                  end else begin
                     cnt_nxt_s = CNT_BITS'(MULDIV_CYCLES - 2);
                  end
               end else if (hz.ex_branch_taken) begin
                  hz.if_id_zero = 1'b1;
                  hz.id_ex_zero = 1'b1;
               end else if (load_use_s) begin
                  hz.pc_en      = 1'b0;
                  hz.if_id_en   = 1'b0;
                  hz.id_ex_zero = 1'b1;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            default: begin
               // Corrupted state encoding: flush the pipe and fall back to RUN.
               {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en} = 5'b00000;
               {hz.if_id_zero, hz.id_ex_zero, hz.ex_mem_zero, hz.mem_wb_zero} = 4'b1111;
               state_nxt_s = ST_RUN;
               cnt_nxt_s   = {CNT_BITS{1'b0}};
            end
         endcase
      end
   end

   // Sequencer state, mul/div countdown and the state to return to after HALT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_RUN;
         cnt_r      <= {CNT_BITS{1'b0}};
         saved_md_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         saved_md_r <= saved_md_nxt_s;
      end
   end

`ifdef HAZARD_CTRL_PERF_EN
   logic lu_evt_s;
   logic md_evt_s;
   logic br_evt_s;

   // Each hazard response has a unique enable/clear signature, so events are decoded from it.
   assign lu_evt_s = hz.id_ex_zero & ~hz.if_id_zero;
   assign md_evt_s = hz.mem_wb_zero & ~hz.ex_mem_zero;
   assign br_evt_s = hz.if_id_zero & hz.pc_en;

   // Event counters, free-running with natural 32-bit wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_lu_cnt <= 32'd0;
         perf_md_cnt <= 32'd0;
         perf_br_cnt <= 32'd0;
      end else begin
         perf_lu_cnt <= perf_lu_cnt + {31'd0, lu_evt_s};
         perf_md_cnt <= perf_md_cnt + {31'd0, md_evt_s};
         perf_br_cnt <= perf_br_cnt + {31'd0, br_evt_s};
      end
   end
`endif

endmodule
